// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-flop synchronises rx, samples each bit mid-period off the system
// clock, and emits the recovered byte with a one-cycle valid (or frame_err) strobe.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e               state_q;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 line_seen_high_q;

  assign rx_s = sync_q[1];
  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      cnt_q            <= '0;
      idx_q            <= '0;
      shift_q          <= '0;
      data             <= '0;
      valid            <= 1'b0;
      frame_err        <= 1'b0;
      line_seen_high_q <= 1'b1;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rx_s) begin
            line_seen_high_q <= 1'b1;
          end else if (line_seen_high_q) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            // A start bit that is high again by mid-bit is treated as a glitch.
            if (!rx_s) begin
              state_q <= StData;
              idx_q   <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StData: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == LAST_IDX) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StStop: begin
          if (cnt_q == LAST_CNT) begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught.
            cnt_q   <= '0;
            state_q <= StIdle;
            if (rx_s) begin
              data  <= shift_q;
              valid <= 1'b1;
            end else begin
              frame_err        <= 1'b1;
              line_seen_high_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (16 clocks/bit) for protocol corners and a
// 115200-baud instance (868 clocks/bit) for a "Hi" sanity run.
module tb_uart_rx;

  localparam int unsigned CPB_A = 16;
  localparam int unsigned CPB_B = 868;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, fe_a, fe_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int fe_cnt_a = 0;
  int fe_cnt_b = 0;
  int fe_base;
  logic both_seen = 1'b0;
  logic busy_seen = 1'b0;
  int         vq_cyc[$];
  logic [7:0] vq_data[$];
  logic [7:0] hq_data[$];

  uart_rx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) u_dut (
    .clk(clk), .reset(reset), .rx(rx_a),
    .data(data_a), .valid(valid_a), .frame_err(fe_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) u_hi (
    .clk(clk), .reset(reset), .rx(rx_b),
    .data(data_b), .valid(valid_b), .frame_err(fe_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid_a) begin
      vq_cyc.push_back(cyc);
      vq_data.push_back(data_a);
    end
    if (fe_a) fe_cnt_a++;
    if (valid_a && fe_a) both_seen = 1'b1;
    if (valid_b && fe_b) both_seen = 1'b1;
    if (busy_a) busy_seen = 1'b1;
    if (valid_b) hq_data.push_back(data_b);
    if (fe_b) fe_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame on rx_a (sel 0) or rx_b (sel 1); the line is left at the stop value.
  task automatic send(input int sel, input logic [7:0] b, input logic stop);
    int cpb;
    cpb = (sel == 0) ? CPB_A : CPB_B;
    last_fall = cyc;
    if (sel == 0) rx_a = 1'b0; else rx_b = 1'b0;
    hold(cpb);
    for (int i = 0; i < 8; i++) begin
      if (sel == 0) rx_a = b[i]; else rx_b = b[i];
      hold(cpb);
    end
    if (sel == 0) rx_a = stop; else rx_b = stop;
    hold(cpb);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'hC3;

    // Reset values while reset is held.
    #3;
    check("rst_data", {24'h0, data_a}, 32'h0);
    check("rst_valid", {31'h0, valid_a}, 32'h0);
    check("rst_frame_err", {31'h0, fe_a}, 32'h0);
    check("rst_busy", {31'h0, busy_a}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(10);

    // Single frame with latency, counted inclusive of the cycle in which rx falls.
    send(0, 8'hA5, 1'b1);
    hold(20);
    check("a5_count", vq_cyc.size(), 1);
    check("a5_data", {24'h0, vq_data[0]}, 32'hA5);
    check("a5_latency", vq_cyc[0] - last_fall + 1, 156);
    check("a5_no_fe", fe_cnt_a, 0);
    check("a5_held", {24'h0, data_a}, 32'hA5);

    // Back-to-back frames with zero idle gap.
    vq_cyc.delete();
    vq_data.delete();
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    send(0, 8'h3C, 1'b1);
    hold(20);
    check("b2b_count", vq_cyc.size(), 3);
    check("b2b_data0", {24'h0, vq_data[0]}, 32'h00);
    check("b2b_data1", {24'h0, vq_data[1]}, 32'hFF);
    check("b2b_data2", {24'h0, vq_data[2]}, 32'h3C);
    check("b2b_gap01", vq_cyc[1] - vq_cyc[0], 160);
    check("b2b_gap12", vq_cyc[2] - vq_cyc[1], 160);

    // Short glitch must not start a frame.
    vq_cyc.delete();
    vq_data.delete();
    busy_seen = 1'b0;
    fe_base = fe_cnt_a;
    rx_a = 1'b0;
    hold(5);
    rx_a = 1'b1;
    hold(25);
    check("glitch_busy_seen", {31'h0, busy_seen}, 32'h1);
    check("glitch_busy_idle", {31'h0, busy_a}, 32'h0);
    check("glitch_no_valid", vq_cyc.size(), 0);
    check("glitch_no_fe", fe_cnt_a - fe_base, 0);
    send(0, 8'h55, 1'b1);
    hold(20);
    check("post_glitch_count", vq_cyc.size(), 1);
    check("post_glitch_data", {24'h0, vq_data[0]}, 32'h55);

    // Framing error followed by a held-low line, then recovery.
    vq_cyc.delete();
    vq_data.delete();
    fe_base = fe_cnt_a;
    send(0, 8'h81, 1'b0);
    hold(3 * CPB_A);
    rx_a = 1'b1;
    hold(30);
    check("fe_one_pulse", fe_cnt_a - fe_base, 1);
    check("fe_no_valid", vq_cyc.size(), 0);
    check("fe_data_kept", {24'h0, data_a}, 32'h55);
    send(0, 8'h42, 1'b1);
    hold(20);
    check("post_fe_count", vq_cyc.size(), 1);
    check("post_fe_data", {24'h0, vq_data[0]}, 32'h42);

    // Reset in the middle of data bit 4.
    vq_cyc.delete();
    vq_data.delete();
    rx_a = 1'b0;
    hold(CPB_A);
    for (int i = 0; i < 4; i++) begin
      rx_a = partial[i];
      hold(CPB_A);
    end
    rx_a = partial[4];
    hold(CPB_A / 2);
    check("pre_reset_busy", {31'h0, busy_a}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset_busy", {31'h0, busy_a}, 32'h0);
    check("mid_reset_valid", {31'h0, valid_a}, 32'h0);
    check("mid_reset_data", {24'h0, data_a}, 32'h0);
    rx_a = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(2 * CPB_A);
    check("post_reset_no_strobe", vq_cyc.size(), 0);
    send(0, 8'h7E, 1'b1);
    hold(20);
    check("post_reset_count", vq_cyc.size(), 1);
    check("post_reset_data", {24'h0, vq_data[0]}, 32'h7E);

    // "Hi" at 115200 baud.
    send(1, 8'h48, 1'b1);
    send(1, 8'h69, 1'b1);
    hold(CPB_B);
    check("hi_count", hq_data.size(), 2);
    check("hi_data0", {24'h0, hq_data[0]}, 32'h48);
    check("hi_data1", {24'h0, hq_data[1]}, 32'h69);
    check("hi_no_fe", fe_cnt_b, 0);

    check("never_both_strobes", {31'h0, both_seen}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the board's UART transmit path.
- Samples the asynchronous PMOD receive pin on the 100 MHz system clock and recovers bytes (LSB first).
- Presents each byte with a one-cycle valid strobe for downstream logic (LEDs, command decoder, loopback to TX).
- Runs directly off `clk` with an internal bit-timing counter; no derived UART clock.

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit (100 MHz / 115200 baud); legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  raw serial line, idle high, asynchronous to clk.
- data  output  DATA_BITS  last good received byte; held until the next good frame.
- valid  output  1  one-cycle pulse; data is new in this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:

Reset (asynchronous, active-high):
- Synchroniser flops = 1.
- state = IDLE; bit counter, bit index and shift register = 0.
- data = 0, valid = 0, frame_err = 0, busy = 0.
- line_seen_high = 1.

Input synchronisation:
- rx passes through a 2-flop synchroniser to give rx_s.
- All decisions use rx_s only.

Counters:
- Bit-timing counter cnt: width clog2(CLKS_PER_BIT), cleared on every state change.
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- Bit index: width clog2(DATA_BITS).

State machine:
- IDLE:
  - If rx_s == 1, set line_seen_high = 1.
  - If rx_s == 0 and line_seen_high == 1, go to START with cnt = 0.
- START:
  - cnt increments each cycle.
  - At cnt == HALF, sample rx_s:
    - rx_s == 0: go to DATA with cnt = 0, index = 0.
    - rx_s == 1 (glitch): return to IDLE, no strobe.
- DATA:
  - At cnt == CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift, so LSB-first bits land in order) and clear cnt.
  - After the DATA_BITS-th sample, go to STOP.
  - Otherwise increment index.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample rx_s.
  - rx_s == 1: data <= shift register; valid = 1 for the next cycle only.
  - rx_s == 0: frame_err = 1 for the next cycle only; data unchanged; line_seen_high = 0.
  - Either way, return to IDLE.

Timing and latency:
- Sampling happens mid-bit.
- A low rx_s seen in IDLE at cycle T gives valid/frame_err high at cycle T + 1 + HALF + 1 + (DATA_BITS+1)*CLKS_PER_BIT + 1.
- Rx pin to synchroniser adds 2 more cycles.

Boundary conditions:
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start bit immediately after the stop bit is caught with zero idle time.
- Break or stuck-low line: after a framing error, no new frame starts until rx_s has been high for at least one cycle. Exactly one frame_err per break.
- valid and frame_err are never high in the same cycle.
- reset mid-frame aborts immediately; no strobe is emitted; data returns to 0.
- rx toggling while in DATA/STOP between sample points is ignored.

Test Plan:
- CLKS_PER_BIT=16, reset, idle high, send 0xA5 (8N1) -> valid one cycle, data==0xA5, frame_err never high; valid rises 1+7+1+9*16+1+2 = 156 cycles after rx falls.
- Send 0x00, 0xFF and 0x3C back-to-back with zero idle gap -> three valid pulses spaced exactly 160 cycles apart; data 0x00, 0xFF, 0x3C in order.
- rx low pulse of 5 cycles, then high -> no valid, no frame_err; busy high then back to 0; a following 0x55 frame is received correctly.
- Frame 0x81 with stop bit driven low, line held low for 3 bit times then released -> exactly one frame_err pulse, data keeps its previous value; a following 0x42 frame gives valid with data==0x42.
- Assert reset during bit 4 of a frame -> busy, valid and data go to 0 asynchronously; no strobe; the next full frame 0x7E is received correctly.
- CLKS_PER_BIT=868 sanity run, send "Hi" at 115200 baud from the bench model -> data 0x48 then 0x69, both with valid.
